// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared register offsets and defaults for the button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam logic BTN_REG_LEVEL        = 1'b0;
    localparam logic BTN_REG_EVENTS       = 1'b1;
    localparam int   BTN_REL_SHIFT        = 8;
    localparam int   BTN_DEBOUNCE_DEFAULT = 270000;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button channel: 2-FF synchroniser, stability counter,
//               debounced level plus press/release strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             w_sync;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    // Chain resets to 1 so a released pad never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_raw_n};
        end
    end

    assign w_sync = ~r_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_stable;
    assign o_press   = r_stable & ~r_stable_d;
    assign o_release = ~r_stable & r_stable_d;

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounced game buttons with sticky W1C event flags behind a
//               sel/ready bus slave. Define BUTTON_RELEASE_EVENTS_EN to add
//               release flags in EVENTS[15:8].
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 5,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons_level,
    input  logic                   btn_sel,
    input  logic                   btn_addr,
    input  logic                   btn_we,
    input  logic [31:0]            btn_data_i,
    output logic                   btn_ready,
    output logic [31:0]            btn_data_o
);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_channel
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_channel (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_raw_n   (buttons_raw[gi]),
                .o_level   (w_level[gi]),
                .o_press   (w_press[gi]),
                .o_release (w_release[gi])
            );
        end
    endgenerate

    assign buttons_level = w_level;

    logic                   r_ready;
    logic                   r_addr;
    logic                   w_access;
    logic                   w_evt_wr;
    logic [NUM_BUTTONS-1:0] r_press_flags;
    logic [NUM_BUTTONS-1:0] w_press_clr;
    logic [31:0]            w_rel_word;
    logic [31:0]            w_events_word;

    assign w_access    = btn_sel & ~r_ready;
    assign w_evt_wr    = w_access & btn_we & (btn_addr == BTN_REG_EVENTS);
    assign w_press_clr = w_evt_wr ? btn_data_i[NUM_BUTTONS-1:0] : '0;

    // Clear is applied before set so a same-cycle strobe survives the W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready       <= 1'b0;
            r_addr        <= 1'b0;
            r_press_flags <= '0;
        end else begin
            r_ready       <= w_access;
            r_press_flags <= (r_press_flags & ~w_press_clr) | w_press;
            if (w_access) begin
                r_addr <= btn_addr;
            end
        end
    end

`ifdef BUTTON_RELEASE_EVENTS_EN
    logic [NUM_BUTTONS-1:0] r_rel_flags;
    logic [NUM_BUTTONS-1:0] w_rel_clr;

    assign w_rel_clr = w_evt_wr ? btn_data_i[BTN_REL_SHIFT +: NUM_BUTTONS] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rel_flags <= '0;
        end else begin
            r_rel_flags <= (r_rel_flags & ~w_rel_clr) | w_release;
        end
    end

    assign w_rel_word = 32'(r_rel_flags) << BTN_REL_SHIFT;
`else
    assign w_rel_word = '0;
`endif

    assign w_events_word = w_rel_word | 32'(r_press_flags);

    always_comb begin
        btn_data_o = '0;
        if (r_ready) begin
            btn_data_o = (r_addr == BTN_REG_EVENTS) ? w_events_word : 32'(w_level);
        end
    end

    assign btn_ready = r_ready;

    logic w_unused;
    assign w_unused = ^{btn_data_i, w_release};

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Directed self-checking bench for button_debouncer
//               (NUM_BUTTONS=5, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int   NB      = 5;
    localparam logic A_LEVEL = 1'b0;
    localparam logic A_EVENT = 1'b1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] buttons_raw;
    logic [NB-1:0] buttons_level;
    logic          btn_sel;
    logic          btn_addr;
    logic          btn_we;
    logic [31:0]   btn_data_i;
    logic          btn_ready;
    logic [31:0]   btn_data_o;

    int n_cmp = 0;
    int n_err = 0;

    button_debouncer #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons_raw   (buttons_raw),
        .buttons_level (buttons_level),
        .btn_sel       (btn_sel),
        .btn_addr      (btn_addr),
        .btn_we        (btn_we),
        .btn_data_i    (btn_data_i),
        .btn_ready     (btn_ready),
        .btn_data_o    (btn_data_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input string tag, input logic addr, input logic [31:0] exp);
        btn_sel  = 1'b1;
        btn_addr = addr;
        btn_we   = 1'b0;
        tick();
        check_eq({tag, "_ready"}, 32'(btn_ready), 32'd1);
        check_eq({tag, "_data"}, btn_data_o, exp);
        tick();
        check_eq({tag, "_ready_once"}, 32'(btn_ready), 32'd0);
        check_eq({tag, "_data_idle"}, btn_data_o, 32'd0);
        btn_sel = 1'b0;
    endtask

    task automatic bus_write(input string tag, input logic addr, input logic [31:0] data);
        btn_sel    = 1'b1;
        btn_addr   = addr;
        btn_we     = 1'b1;
        btn_data_i = data;
        tick();
        check_eq({tag, "_ack"}, 32'(btn_ready), 32'd1);
        btn_sel    = 1'b0;
        btn_we     = 1'b0;
        btn_data_i = '0;
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        buttons_raw = '0;
        btn_sel     = 1'b0;
        btn_addr    = 1'b0;
        btn_we      = 1'b0;
        btn_data_i  = '0;

        // Reset state, then all pads held pressed across reset release.
        tick(3);
        check_eq("rst_level", 32'(buttons_level), 32'd0);
        check_eq("rst_ready", 32'(btn_ready), 32'd0);
        check_eq("rst_data", btn_data_o, 32'd0);
        reset_n = 1'b1;
        tick(5);
        check_eq("all_level_early", 32'(buttons_level), 32'd0);
        tick();
        check_eq("all_level_6cyc", 32'(buttons_level), 32'h1F);

        // Release everything and clear every flag.
        buttons_raw = 5'h1F;
        tick(10);
        check_eq("all_released", 32'(buttons_level), 32'd0);
        bus_write("clr_all", A_EVENT, 32'hFFFF_FFFF);
        bus_read("evt_clear", A_EVENT, 32'd0);

        // Bounce rejection on button 0.
        for (int k = 0; k < 5; k++) begin
            buttons_raw[0] = 1'b0;
            tick(3);
            buttons_raw[0] = 1'b1;
            tick();
            check_eq("bounce_level", 32'(buttons_level[0]), 32'd0);
        end
        tick(4);
        check_eq("bounce_settled", 32'(buttons_level), 32'd0);
        bus_read("bounce_evt", A_EVENT, 32'd0);

        // Press button 2; read right as the flag lands.
        buttons_raw[2] = 1'b0;
        tick(5);
        check_eq("p2_early", 32'(buttons_level), 32'd0);
        tick();
        check_eq("p2_level", 32'(buttons_level), 32'h04);
        bus_read("p2_evt", A_EVENT, 32'h4);

        // Press button 4, then W1C.
        buttons_raw[4] = 1'b0;
        tick(8);
        bus_read("p4_evt", A_EVENT, 32'h14);
        bus_write("w1c_b2", A_EVENT, 32'h4);
        bus_read("after_w1c", A_EVENT, 32'h10);
        bus_write("w1c_zero", A_EVENT, 32'h0);
        bus_read("after_w0", A_EVENT, 32'h10);

        // Clear of bit 1 lands on the same edge as its press flag sets.
        buttons_raw[1] = 1'b0;
        tick(6);
        check_eq("p1_level", 32'(buttons_level), 32'h16);
        bus_write("collide", A_EVENT, 32'h2);
        bus_read("collide_evt", A_EVENT, 32'h12);
        bus_write("w1c_b1", A_EVENT, 32'h2);
        bus_read("after_b1", A_EVENT, 32'h10);

        // LEVEL reads current state; writes are acked but ignored.
        bus_read("lvl_rd", A_LEVEL, 32'h16);
        bus_write("lvl_wr", A_LEVEL, 32'hFF);
        bus_read("lvl_rd2", A_LEVEL, 32'h16);

        // Release all, clear, then press/release button 4.
        buttons_raw = 5'h1F;
        tick(8);
        bus_write("clr_all2", A_EVENT, 32'hFFFF_FFFF);
        bus_read("evt_clear2", A_EVENT, 32'd0);
        buttons_raw[4] = 1'b0;
        tick(8);
        buttons_raw[4] = 1'b1;
        tick(8);
`ifdef BUTTON_RELEASE_EVENTS_EN
        bus_read("rel_evt", A_EVENT, 32'h1010);
`else
        bus_read("rel_evt", A_EVENT, 32'h10);
`endif

        // Reset mid-debounce and mid-access.
        buttons_raw[3] = 1'b0;
        tick(4);
        btn_sel  = 1'b1;
        btn_addr = A_LEVEL;
        tick();
        check_eq("mid_ready", 32'(btn_ready), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_ready", 32'(btn_ready), 32'd0);
        check_eq("async_data", btn_data_o, 32'd0);
        btn_sel = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check_eq("p3_restart_early", 32'(buttons_level), 32'd0);
        tick();
        check_eq("p3_restart", 32'(buttons_level), 32'h08);
        tick(2);
        bus_read("post_rst_evt", A_EVENT, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
